// File: rtl/fetch_inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue_pkg
// Shared types and widths for the fetch-to-decode instruction queue.
//   fetch_queue_entry_t : full entry as seen by decode {pc, instruction, address_valid}
//   fetch_data_t        : fill-time half of an entry {instruction, address_valid}
// -----------------------------------------------------------------------------
package fetch_inst_queue_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // One complete queue entry, assembled from the PC array and the data array.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
    logic               address_valid;
  } fetch_queue_entry_t;

  // The part of an entry written when the memory response comes back.
  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic               address_valid;
  } fetch_data_t;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue_if
// Bundles the fetch-side and decode-side signals of the instruction queue.
//   master : the fetch/decode pipeline (drives requests, fills, acks, flush)
//   slave  : the queue itself (drives availability, pc_id, decode outputs)
// Parameter DEPTH must match the queue instance it is connected to.
// -----------------------------------------------------------------------------
interface fetch_inst_queue_if #(
  parameter int DEPTH = 4
);
  import fetch_inst_queue_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic               flush;
  logic               pc_id_assigned;
  logic [PC_W-1:0]    if_pc;
  logic               pc_id_available;
  logic [IDX_W-1:0]   pc_id;
  logic               fetch_complete;
  logic [INSTR_W-1:0] fetch_instruction;
  logic               fetch_address_valid;
  logic               decode_valid;
  logic [PC_W-1:0]    decode_pc;
  logic [INSTR_W-1:0] decode_instruction;
  logic               decode_address_valid;
  logic               decode_ack;
  logic [IDX_W:0]     occupancy;

  modport master (
    output flush, pc_id_assigned, if_pc, fetch_complete, fetch_instruction,
           fetch_address_valid, decode_ack,
    input  pc_id_available, pc_id, decode_valid, decode_pc, decode_instruction,
           decode_address_valid, occupancy
  );

  modport slave (
    input  flush, pc_id_assigned, if_pc, fetch_complete, fetch_instruction,
           fetch_address_valid, decode_ack,
    output pc_id_available, pc_id, decode_valid, decode_pc, decode_instruction,
           decode_address_valid, occupancy
  );

endinterface

// File: rtl/fetch_inst_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
// DEPTH x WIDTH storage with one synchronous write port and one asynchronous
// read port. Contents are never reset; the queue pointers decide what is live.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single write port; no reset so this maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is asynchronous so decode sees the oldest entry in the same cycle
  // the issue pointer moves onto it.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_inst_queue.sv
// -----------------------------------------------------------------------------
// fetch_inst_queue
// In-order queue between fetch and decode. An entry is allocated (with its PC)
// when fetch launches a request, filled with the instruction word when the
// response arrives, and handed to decode through a valid/ack handshake.
//   clk : clock
//   rst : synchronous, active-high reset (same effect as flush)
//   bus : fetch_inst_queue_if.slave
//         in : flush, pc_id_assigned, if_pc, fetch_complete,
//              fetch_instruction, fetch_address_valid, decode_ack
//         out: pc_id_available, pc_id, decode_valid, decode_pc,
//              decode_instruction, decode_address_valid, occupancy
// -----------------------------------------------------------------------------
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_inst_queue_if.slave       bus
);

  localparam int             IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_DEPTH = (IDX_W+1)'(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [IDX_W:0] r_allocPtr;
  logic [IDX_W:0] r_fillPtr;
  logic [IDX_W:0] r_issuePtr;

  logic               w_occupancyFull;
  logic               w_decodeValid;
  logic               w_unfilledPending;
  logic               w_allocEn;
  logic               w_fillEn;
  logic               w_issueEn;
  logic [IDX_W:0]     w_occupancy;
  fetch_data_t        w_fillData;
  fetch_data_t        w_issueData;
  logic [PC_W-1:0]    w_issuePc;
  fetch_queue_entry_t w_issueEntry;

  // Status derived from registered pointers only, so an ack in this cycle
  // frees its slot for allocation only from the next cycle on.
  assign w_occupancy       = r_allocPtr - r_issuePtr;
  assign w_occupancyFull   = (w_occupancy == PTR_DEPTH);
  assign w_decodeValid     = (r_fillPtr != r_issuePtr);
  assign w_unfilledPending = (r_fillPtr != r_allocPtr);

  // Illegal requests are dropped rather than corrupting the pointers;
  // flush drops everything issued in its cycle.
  assign w_allocEn = bus.pc_id_assigned & ~w_occupancyFull   & ~bus.flush;
  assign w_fillEn  = bus.fetch_complete & w_unfilledPending  & ~bus.flush;
  assign w_issueEn = bus.decode_ack     & w_decodeValid      & ~bus.flush;

  assign w_fillData = '{instruction:   bus.fetch_instruction,
                        address_valid: bus.fetch_address_valid};

  // Pointer update: allocate, fill and issue advance independently, and
  // reset/flush return all three to zero without touching the storage.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_allocPtr <= '0;
      r_fillPtr  <= '0;
      r_issuePtr <= '0;
    end else begin
      if (w_allocEn) r_allocPtr <= r_allocPtr + 1'b1;
      if (w_fillEn)  r_fillPtr  <= r_fillPtr  + 1'b1;
      if (w_issueEn) r_issuePtr <= r_issuePtr + 1'b1;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W)
  ) pcRam (
    .clk     (clk),
    .i_we    (w_allocEn),
    .i_waddr (r_allocPtr[IDX_W-1:0]),
    .i_wdata (bus.if_pc),
    .i_raddr (r_issuePtr[IDX_W-1:0]),
    .o_rdata (w_issuePc)
  );

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_data_t))
  ) dataRam (
    .clk     (clk),
    .i_we    (w_fillEn),
    .i_waddr (r_fillPtr[IDX_W-1:0]),
    .i_wdata (w_fillData),
    .i_raddr (r_issuePtr[IDX_W-1:0]),
    .o_rdata (w_issueData)
  );

  assign w_issueEntry = '{pc:            w_issuePc,
                          instruction:   w_issueData.instruction,
                          address_valid: w_issueData.address_valid};

  assign bus.pc_id_available      = ~w_occupancyFull;
  assign bus.pc_id                = r_allocPtr[IDX_W-1:0];
  assign bus.occupancy            = w_occupancy;
  assign bus.decode_valid         = w_decodeValid;
  assign bus.decode_pc            = w_issueEntry.pc;
  assign bus.decode_instruction   = w_issueEntry.instruction;
  assign bus.decode_address_valid = w_issueEntry.address_valid;

  // Protocol checks: allocating into a full queue, completing a fetch that
  // was never launched, and acking while nothing is valid.
  allocWhenFull: assert property (@(posedge clk) disable iff (rst)
    bus.pc_id_assigned |-> ~w_occupancyFull);

  fillWithoutRequest: assert property (@(posedge clk) disable iff (rst)
    bus.fetch_complete |-> w_unfilledPending);

  ackWithoutValid: assert property (@(posedge clk) disable iff (rst)
    bus.decode_ack |-> w_decodeValid);

endmodule

// File: tb/tb_fetch_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_inst_queue
// Self-checking bench for fetch_inst_queue. A queue-based reference model
// (launched-but-unfilled PCs, filled-but-unissued entries) predicts every
// output after each clock; directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_fetch_inst_queue;
  import fetch_inst_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  fetch_inst_queue_if #(.DEPTH(DEPTH)) qIf ();

  fetch_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (qIf)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        av;
  } readyEntry_t;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] pendingQ[$];
  readyEntry_t readyQ[$];
  int          allocTotal = 0;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int modelOcc();
    return pendingQ.size() + readyQ.size();
  endfunction

  // Compare every visible output against the model's view of the queue.
  task automatic checkModel(input string tag);
    checkOutput({tag, " valid"}, 64'(qIf.decode_valid), 64'(readyQ.size() > 0));
    checkOutput({tag, " occ"}, 64'(qIf.occupancy), 64'(modelOcc()));
    checkOutput({tag, " pc_id"}, 64'(qIf.pc_id), 64'(allocTotal % DEPTH));
    checkOutput({tag, " avail"}, 64'(qIf.pc_id_available), 64'(modelOcc() != DEPTH));
    if (readyQ.size() > 0) begin
      checkOutput({tag, " pc"}, 64'(qIf.decode_pc), 64'(readyQ[0].pc));
      checkOutput({tag, " instr"}, 64'(qIf.decode_instruction), 64'(readyQ[0].instr));
      checkOutput({tag, " av"}, 64'(qIf.decode_address_valid), 64'(readyQ[0].av));
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, check.
  task automatic applyStimulus(input bit alloc, input logic [31:0] pc,
                               input bit fill, input logic [31:0] instr,
                               input bit av, input bit ack, input bit fl);
    readyEntry_t e;
    qIf.pc_id_assigned      = alloc;
    qIf.if_pc               = pc;
    qIf.fetch_complete      = fill;
    qIf.fetch_instruction   = instr;
    qIf.fetch_address_valid = av;
    qIf.decode_ack          = ack;
    qIf.flush               = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      pendingQ.delete();
      readyQ.delete();
      allocTotal = 0;
    end else begin
      if (ack) void'(readyQ.pop_front());
      if (fill) begin
        e.pc    = pendingQ.pop_front();
        e.instr = instr;
        e.av    = av;
        readyQ.push_back(e);
      end
      if (alloc) begin
        pendingQ.push_back(pc);
        allocTotal++;
      end
    end
    qIf.pc_id_assigned = 1'b0;
    qIf.fetch_complete = 1'b0;
    qIf.decode_ack     = 1'b0;
    qIf.flush          = 1'b0;
    checkModel("model");
  endtask

  task automatic resetDut();
    rst = 1'b1;
    qIf.pc_id_assigned = 1'b0;
    qIf.fetch_complete = 1'b0;
    qIf.decode_ack     = 1'b0;
    qIf.flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pendingQ.delete();
    readyQ.delete();
    allocTotal = 0;
    checkOutput("reset valid", 64'(qIf.decode_valid), 64'd0);
    checkOutput("reset avail", 64'(qIf.pc_id_available), 64'd1);
    checkOutput("reset pc_id", 64'(qIf.pc_id), 64'd0);
    checkOutput("reset occ", 64'(qIf.occupancy), 64'd0);
  endtask

  // Main sequence: directed scenarios, then a long randomized run.
  initial begin
    logic [31:0] base;
    rst                     = 1'b1;
    qIf.pc_id_assigned      = 1'b0;
    qIf.if_pc               = '0;
    qIf.fetch_complete      = 1'b0;
    qIf.fetch_instruction   = '0;
    qIf.fetch_address_valid = 1'b0;
    qIf.decode_ack          = 1'b0;
    qIf.flush               = 1'b0;

    // Single allocate, fill two cycles later, then ack.
    resetDut();
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1 not yet valid", 64'(qIf.decode_valid), 64'd0);
    applyStimulus(0, 0, 1, 32'h0000_0013, 1, 0, 0);
    checkOutput("t1 valid", 64'(qIf.decode_valid), 64'd1);
    checkOutput("t1 pc", 64'(qIf.decode_pc), 64'h8000_0000);
    checkOutput("t1 instr", 64'(qIf.decode_instruction), 64'h0000_0013);
    checkOutput("t1 av", 64'(qIf.decode_address_valid), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t1 occ drained", 64'(qIf.occupancy), 64'd0);

    // Fill the queue, then see availability return one cycle after an ack.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'h3000 + 32'(4*i), 0, 0, 0, 0, 0);
    checkOutput("t2 full avail", 64'(qIf.pc_id_available), 64'd0);
    applyStimulus(0, 0, 1, 32'h1111_0000, 1, 0, 0);
    checkOutput("t2 still full", 64'(qIf.pc_id_available), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t2 avail after ack", 64'(qIf.pc_id_available), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back allocate/fill/ack with allocations two ahead.
    base = 32'h0000_2000;
    applyStimulus(1, base, 0, 0, 0, 0, 0);
    applyStimulus(1, base + 32'd4, 1, base ^ 32'hdead_beef, 1, 0, 0);
    for (int i = 0; i < 3*DEPTH; i++) begin
      checkOutput("t3 stream valid", 64'(qIf.decode_valid), 64'd1);
      checkOutput("t3 stream pc", 64'(qIf.decode_pc), 64'(base + 32'(4*i)));
      applyStimulus(1, base + 32'(4*(i+2)), 1, (base + 32'(4*(i+1))) ^ 32'hdead_beef,
                    1, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Access fault propagates with its PC.
    applyStimulus(1, 32'h0000_1000, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'hffff_ffff, 0, 0, 0);
    checkOutput("t4 av", 64'(qIf.decode_address_valid), 64'd0);
    checkOutput("t4 pc", 64'(qIf.decode_pc), 64'h0000_1000);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Flush with work in flight and a simultaneous allocate and fill.
    applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4004, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h4008, 1, 32'h0000_0033, 1, 0, 0);
    applyStimulus(1, 32'h400c, 1, 32'h0000_0037, 1, 0, 1);
    checkOutput("t5 valid", 64'(qIf.decode_valid), 64'd0);
    checkOutput("t5 occ", 64'(qIf.occupancy), 64'd0);
    checkOutput("t5 pc_id", 64'(qIf.pc_id), 64'd0);
    checkOutput("t5 avail", 64'(qIf.pc_id_available), 64'd1);
    applyStimulus(1, 32'h8000_0100, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0013, 1, 0, 0);
    checkOutput("t5 first pc", 64'(qIf.decode_pc), 64'h8000_0100);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);

    // Random legal traffic with occasional flushes.
    for (int c = 0; c < 10000; c++) begin
      bit a, f, k, fl;
      fl = ($urandom_range(0, 199) == 0);
      a  = (modelOcc() != DEPTH) && ($urandom_range(0, 3) != 0);
      f  = (pendingQ.size() > 0) && ($urandom_range(0, 2) != 0);
      k  = (readyQ.size() > 0) && ($urandom_range(0, 2) != 0);
      applyStimulus(a, $urandom, f, $urandom, 1'($urandom_range(0, 1)), k, fl);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

In-order queue between the fetch stage and decode. It allocates an entry, with its PC, when fetch launches a memory request (`pc_id_assigned`). It fills that entry with the instruction word when fetch reports completion (`fetch_complete`), and presents filled entries to decode through a valid/ack handshake. Its free-entry count drives fetch's `pc_id_available` backpressure, which bounds the number of outstanding fetches to `DEPTH`.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `IDX_W`, `$clog2(DEPTH)`: entry index width (derived).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: discard all entries, allocated, filled and in flight; driven by `gc_fetch_flush | branch_flush`.
- `pc_id_assigned` in 1: fetch launched a request this cycle; allocate an entry.
- `if_pc` in 32: PC of the launched request; sampled when `pc_id_assigned` is high.
- `pc_id_available` out 1: at least one unallocated entry exists.
- `pc_id` out `IDX_W`: index that the next allocation will use.
- `fetch_complete` in 1: the oldest unfilled entry's data is valid this cycle.
- `fetch_instruction` in 32: instruction word; sampled when `fetch_complete` is high.
- `fetch_address_valid` in 1: 0 marks an access fault; sampled when `fetch_complete` is high.
- `decode_valid` out 1: the oldest entry is filled.
- `decode_pc` out 32: PC of the oldest entry.
- `decode_instruction` out 32: instruction of the oldest entry.
- `decode_address_valid` out 1: address-valid flag of the oldest entry.
- `decode_ack` in 1: decode consumed the oldest entry; legal only while `decode_valid` is high.
- `occupancy` out `IDX_W+1`: number of allocated entries (alloc − issue).

## Operation
- Three pointers, each `IDX_W+1` bits, wrap modulo `2*DEPTH`:
  - `alloc_ptr`: next entry to allocate.
  - `fill_ptr`: oldest unfilled entry.
  - `issue_ptr`: oldest unissued entry.
- Invariant: `issue_ptr ≤ fill_ptr ≤ alloc_ptr`, compared as modular distances.
- Entry index is the low `IDX_W` bits of a pointer.
- Allocation on `pc_id_assigned`:
  - Write `if_pc` into entry `alloc_ptr`.
  - Increment `alloc_ptr`.
- Fill on `fetch_complete`:
  - Write `fetch_instruction` and `fetch_address_valid` into entry `fill_ptr`.
  - Increment `fill_ptr`.
- Issue on `decode_ack`: increment `issue_ptr`.
- `decode_valid` = (`fill_ptr` != `issue_ptr`). Decode outputs read entry `issue_ptr`.
- `pc_id_available` = (`alloc_ptr − issue_ptr` != `DEPTH`).
  - Computed from registered pointers only.
  - A same-cycle `decode_ack` does not raise it; it rises the following cycle.
- Full queue: `pc_id_assigned` while `pc_id_available` = 0 is a protocol error; the allocation is ignored and an assertion fires.
- `fetch_complete` with `fill_ptr == alloc_ptr` is an error; it is ignored and an assertion fires.
- `decode_ack` with `decode_valid` = 0 is ignored and an assertion fires.
- Allocate, fill and ack in the same cycle are independent and all take effect.
- Flush:
  - All pointers return to 0 next cycle.
  - Same-cycle allocate, fill and ack are dropped.
  - Entry contents are not cleared.
- Reset has the same effect as flush.

## Timing
- Reset and flush values:
  - `decode_valid` = 0.
  - `pc_id_available` = 1.
  - `pc_id` = 0.
  - `occupancy` = 0.
  - `decode_pc`, `decode_instruction` and `decode_address_valid` are don't-care while `decode_valid` = 0.
- Fill latency: `fetch_complete` in cycle N gives `decode_valid` = 1 in cycle N+1. There is no combinational bypass.
- Ack turnaround: `decode_ack` in cycle N moves the decode outputs to the next entry in cycle N+1.
- Sustained throughput is 1 entry per cycle when `DEPTH` ≥ 2 and allocations run at least 2 cycles ahead of acks.
- Flush latency: `flush` in cycle N gives `decode_valid` = 0 and `pc_id_available` = 1 in cycle N+1.

## Structure
- `fetch_queue_entry_t` goes in `taiga_types`: `{pc[31:0], instruction[31:0], address_valid}`.
- Storage sub-module `fetch_queue_ram`:
  - `DEPTH`×33-bit instruction/flag array with one write port (fill) and one async read port (issue).
  - The PC array is a second instance with a 32-bit width.
- Pointer logic and assertions stay in the top module.

## Test plan
- Reset, then one allocation (PC 0x80000000) and a fill 2 cycles later (0x00000013) → `decode_valid` rises in the fill cycle +1 with PC 0x80000000, instruction 0x00000013, `decode_address_valid` = 1; ack → `occupancy` returns to 0.
- `DEPTH` = 4, four allocations, no ack → `pc_id_available` = 0 in the cycle after the 4th allocation; one ack → `pc_id_available` = 1 exactly one cycle later.
- Continuous allocate/fill/ack every cycle over 3·`DEPTH` cycles (PCs incrementing by 4) → outputs are in order with no gaps after fill; pointers wrap correctly.
- Fill with `fetch_address_valid` = 0 for PC 0x00001000 → issued entry shows `decode_address_valid` = 0 and PC 0x00001000.
- Flush with 3 entries allocated and 1 filled, with a simultaneous allocate and fill → next cycle `decode_valid` = 0, `occupancy` = 0, `pc_id` = 0; a new allocation (PC 0x80000100) issues as the first entry.
- Random valid/ack stall pattern against a scoreboard model for 10k cycles → no mismatch and no assertion fires.
